dma_frame_sequencer: RTL and testbench



---
 rtl/dma_frame_sequencer_if.sv | 19 +
 rtl/dma_frame_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dma_frame_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_frame_sequencer_if.sv
// Avalon-MM control-port bundle between the frame sequencer (master)
// and the read DMA's register slave.
interface dma_frame_sequencer_if;
   logic [4:0]  m_address;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic        m_waitrequest;

   modport master (
      output m_address, m_write, m_writedata, m_byteenable,
      input  m_waitrequest
   );

   modport slave (
      input  m_address, m_write, m_writedata, m_byteenable,
      output m_waitrequest
   );
endinterface

// File: rtl/dma_frame_sequencer.sv
// dma_frame_sequencer: per-frame programming of the read DMA (start address,
// word count, enable), ping-pong buffer selection from writer reports, and
// DMA disable on the end-of-packet beat of the output stream.
// Build option: DMA_SEQ_REPEAT_EN -- start on any completed buffer (have_buf)
// instead of requiring a buffer not yet read (fresh), re-reading the last one.
module dma_frame_sequencer #(
   parameter int                    ADDR_WIDTH = 24,
   parameter logic [ADDR_WIDTH-1:0] BUF0_ADDR  = 24'h000000,
   parameter logic [ADDR_WIDTH-1:0] BUF1_ADDR  = 24'h100000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_enable,
   input  logic [29:0]                  cfg_words,
   input  logic                         frame_start,
   input  logic                         wr_buf_done,
   input  logic                         wr_buf_idx,
   input  logic                         st_valid,
   input  logic                         st_ready,
   input  logic                         st_endofpacket,
   dma_frame_sequencer_if.master        dma,
   output logic                         rd_active,
   output logic                         rd_buf_idx,
   output logic [15:0]                  frame_cnt,
   output logic [15:0]                  skip_cnt,
   output logic                         err_conflict
);

   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_LEN, WR_EN, RUN, WR_DIS} state_t;

   state_t      state_q, state_d;
   logic        fresh_q, fresh_d;
   logic        have_q, have_d;
   logic        latest_q, latest_d;
   logic        rd_buf_q, rd_buf_d;
   logic [29:0] words_q, words_d;
   logic [15:0] frame_q, frame_d;
   logic [15:0] skip_q, skip_d;
   logic        err_q, err_d;
   logic        rd_active_q, rd_active_d;
   logic        m_write_q, m_write_d;
   logic [4:0]  m_addr_q, m_addr_d;
   logic [31:0] m_data_q, m_data_d;

   logic avail, start_ok, accept, eop_beat;

`ifdef DMA_SEQ_REPEAT_EN
   assign avail = have_q;
`else
   assign avail = fresh_q;
`endif

   assign start_ok = frame_start && cfg_enable && avail && (cfg_words != '0);
   assign accept   = m_write_q && !dma.m_waitrequest;
   assign eop_beat = st_valid && st_ready && st_endofpacket;

   // Buffer tracking and conflict flag; a same-cycle wr_buf_done wins over the
   // start's clear so that buffer is still fresh for the next frame.
   always_comb begin
      latest_d = wr_buf_done ? wr_buf_idx : latest_q;
      have_d   = have_q | wr_buf_done;
      fresh_d  = fresh_q;
      if (wr_buf_done)
         fresh_d = 1'b1;
      else if (state_q == IDLE && start_ok)
         fresh_d = 1'b0;
      err_d = err_q | (wr_buf_done && (wr_buf_idx == rd_buf_q) && rd_active_q);
   end

   // Frame FSM next state and counters.
   always_comb begin
      state_d  = state_q;
      rd_buf_d = rd_buf_q;
      words_d  = words_q;
      frame_d  = frame_q;
      skip_d   = skip_q;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d  = WR_ADDR;
               rd_buf_d = latest_q;
               words_d  = cfg_words;
            end else if (frame_start) begin
               skip_d = skip_q + 16'd1;
            end
         end
         WR_ADDR: if (accept) state_d = WR_LEN;
         WR_LEN:  if (accept) state_d = WR_EN;
         WR_EN:   if (accept) state_d = RUN;
         RUN:     if (eop_beat) state_d = WR_DIS;
         WR_DIS: begin
            if (accept) begin
               state_d = IDLE;
               frame_d = frame_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (frame_start && state_q != IDLE)
         skip_d = skip_q + 16'd1;
   end

   // Bus outputs are decoded from the next state so they are registered and
   // naturally hold while a write state is stalled.
   always_comb begin
      m_write_d   = 1'b0;
      m_addr_d    = 5'h00;
      m_data_d    = 32'h0;
      rd_active_d = 1'b1;
      case (state_d)
         IDLE:    rd_active_d = 1'b0;
         WR_ADDR: begin
            m_write_d = 1'b1;
            m_addr_d  = 5'h00;
            m_data_d  = rd_buf_d ? 32'(BUF1_ADDR) : 32'(BUF0_ADDR);
         end
         WR_LEN: begin
            m_write_d = 1'b1;
            m_addr_d  = 5'h04;
            m_data_d  = {2'b00, words_d};
         end
         WR_EN: begin
            m_write_d = 1'b1;
            m_addr_d  = 5'h08;
            m_data_d  = 32'h1;
         end
         WR_DIS: begin
            m_write_d = 1'b1;
            m_addr_d  = 5'h08;
            m_data_d  = 32'h0;
         end
         default: ;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fresh_q     <= 1'b0;
         have_q      <= 1'b0;
         latest_q    <= 1'b0;
         rd_buf_q    <= 1'b0;
         words_q     <= '0;
         frame_q     <= '0;
         skip_q      <= '0;
         err_q       <= 1'b0;
         rd_active_q <= 1'b0;
         m_write_q   <= 1'b0;
         m_addr_q    <= '0;
         m_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         fresh_q     <= fresh_d;
         have_q      <= have_d;
         latest_q    <= latest_d;
         rd_buf_q    <= rd_buf_d;
         words_q     <= words_d;
         frame_q     <= frame_d;
         skip_q      <= skip_d;
         err_q       <= err_d;
         rd_active_q <= rd_active_d;
         m_write_q   <= m_write_d;
         m_addr_q    <= m_addr_d;
         m_data_q    <= m_data_d;
      end
   end

   assign dma.m_address    = m_addr_q;
   assign dma.m_write      = m_write_q;
   assign dma.m_writedata  = m_data_q;
   assign dma.m_byteenable = 4'hF;
   assign rd_active        = rd_active_q;
   assign rd_buf_idx       = rd_buf_q;
   assign frame_cnt        = frame_q;
   assign skip_cnt         = skip_q;
   assign err_conflict     = err_q;

endmodule

// File: tb/tb_dma_frame_sequencer.sv
// Bench for dma_frame_sequencer: table of frame scenarios, hand-written
// corner sequences, then randomized frames against a transaction-level model.
module tb_dma_frame_sequencer;
   localparam logic [31:0] B0 = 32'h0000_0000;
   localparam logic [31:0] B1 = 32'h0010_0000;

   logic        clk = 1'b0;
   logic        rst, cfg_enable, frame_start, wr_buf_done, wr_buf_idx;
   logic        st_valid, st_ready, st_endofpacket;
   logic [29:0] cfg_words;
   logic        rd_active, rd_buf_idx, err_conflict;
   logic [15:0] frame_cnt, skip_cnt;

   dma_frame_sequencer_if bus();

   dma_frame_sequencer dut (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_words(cfg_words),
      .frame_start(frame_start), .wr_buf_done(wr_buf_done), .wr_buf_idx(wr_buf_idx),
      .st_valid(st_valid), .st_ready(st_ready), .st_endofpacket(st_endofpacket),
      .dma(bus), .rd_active(rd_active), .rd_buf_idx(rd_buf_idx),
      .frame_cnt(frame_cnt), .skip_cnt(skip_cnt), .err_conflict(err_conflict)
   );

   always #5 clk = ~clk;

   int          vecs = 0, fails = 0, cyc = 0;
   logic [36:0] wq[$];
   int          wc[$];
   bit          prev_stall = 0;
   logic [36:0] prev_bus;
   bit          rand_stall = 0;
   int          len_stall_left = 0, len_cycles = 0;
   int          fs_cyc, eop_cyc;

   // transaction-level model state
   bit          m_latest, m_fresh, m_have, m_rd, m_err;
   logic [15:0] m_frames, m_skips;

   typedef struct {
      bit          idx;
      logic [29:0] words;
      int          stall;
      logic [31:0] exp_addr;
      int          exp_len;
   } vec_t;
   vec_t tbl[4];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: check stall stability, drive waitrequest, log accepted writes.
   task automatic tick();
      bit w;
      @(negedge clk);
      cyc++;
      if (prev_stall)
         check("stall_hold", 64'({bus.m_write, bus.m_address, bus.m_writedata}), 64'({1'b1, prev_bus}));
      w = 1'b0;
      if (len_stall_left > 0 && bus.m_write === 1'b1 && bus.m_address == 5'h04) begin
         w = 1'b1;
         len_stall_left--;
      end else if (rand_stall) begin
         w = ($urandom_range(0, 3) == 0);
      end
      bus.m_waitrequest = w;
      if (bus.m_write === 1'b1 && bus.m_address == 5'h04) len_cycles++;
      prev_bus   = {bus.m_address, bus.m_writedata};
      prev_stall = (bus.m_write === 1'b1) && w && !rst;
      if (bus.m_write === 1'b1 && !w && !rst) begin
         wq.push_back({bus.m_address, bus.m_writedata});
         wc.push_back(cyc);
      end
   endtask

   task automatic st_set(input bit v, input bit r, input bit e);
      st_valid = v; st_ready = r; st_endofpacket = e;
   endtask

   task automatic wdone(input bit idx);
      wr_buf_done = 1'b1; wr_buf_idx = idx;
      tick();
      wr_buf_done = 1'b0;
      m_latest = idx; m_fresh = 1'b1; m_have = 1'b1;
   endtask

   task automatic check_counters();
      check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
      check("skip_cnt", 64'(skip_cnt), 64'(m_skips));
      check("err_conflict", 64'(err_conflict), 64'(m_err));
   endtask

   // mid: 0 none, 1 writer done on the buffer being read, 2 on the other, 3 random
   task automatic frame_req(input logic [29:0] words, input bit en, input bit with_done, input int mid);
      bit go, di;
      int n0, t;
      logic [31:0] ea;
`ifdef DMA_SEQ_REPEAT_EN
      go = en && m_have && (words != 0);
`else
      go = en && m_fresh && (words != 0);
`endif
      di = 1'($urandom_range(0, 1));
      n0 = wq.size();
      len_cycles = 0;
      cfg_words = words; cfg_enable = en; frame_start = 1'b1; fs_cyc = cyc;
      if (with_done) begin wr_buf_done = 1'b1; wr_buf_idx = di; end
      if (go) begin m_rd = m_latest; m_fresh = 1'b0; end
      else m_skips++;
      if (with_done) begin m_latest = di; m_fresh = 1'b1; m_have = 1'b1; end
      st_set(1, 1, 1);   // EOP beats outside RUN must have no effect
      tick();
      frame_start = 1'b0; wr_buf_done = 1'b0;
      if (!go) begin
         repeat (4) tick();
         st_set(0, 0, 0);
         check("skip_no_write", 64'(wq.size()), 64'(n0));
         check("skip_idle", 64'(rd_active), 64'(0));
      end else begin
         ea = m_rd ? B1 : B0;
         t = 0;
         while (wq.size() < n0 + 3 && t < 200) begin tick(); t++; end
         st_set(0, 0, 0);
         check("prog_timeout", 64'(t < 200), 64'(1));
         tick();
         check("run_active", 64'(rd_active), 64'(1));
         check("run_buf", 64'(rd_buf_idx), 64'(m_rd));
         if (mid != 0) begin
            cfg_enable = 1'b0; frame_start = 1'b1; m_skips++;
            st_set(1, 0, 1);   // not accepted
            tick();
            frame_start = 1'b0; st_set(0, 0, 0);
            if (mid == 1) di = m_rd;
            else if (mid == 2) di = !m_rd;
            wr_buf_done = 1'b1; wr_buf_idx = di;
            tick();
            wr_buf_done = 1'b0;
            m_latest = di; m_fresh = 1'b1; m_have = 1'b1;
            if (di == m_rd) m_err = 1'b1;
            check("run_hold", 64'(rd_active), 64'(1));
            check("run_no_write", 64'(wq.size()), 64'(n0 + 3));
         end
         st_set(1, 1, 1); eop_cyc = cyc;
         tick();
         st_set(0, 0, 0); cfg_enable = 1'b1;
         t = 0;
         while (rd_active !== 1'b0 && t < 200) begin tick(); t++; end
         check("dis_timeout", 64'(t < 200), 64'(1));
         m_frames++;
         if (wq.size() >= n0 + 4) begin
            check("w_start", 64'(wq[n0]),   64'({5'h00, ea}));
            check("w_len",   64'(wq[n0+1]), 64'({5'h04, 2'b00, words}));
            check("w_en",    64'(wq[n0+2]), 64'({5'h08, 32'h1}));
            check("w_dis",   64'(wq[n0+3]), 64'({5'h08, 32'h0}));
         end else begin
            check("w_count", 64'(wq.size()), 64'(n0 + 4));
         end
      end
      check_counters();
   endtask

   initial begin
      int n0;
      rst = 1'b1; cfg_enable = 1'b0; cfg_words = '0; frame_start = 1'b0;
      wr_buf_done = 1'b0; wr_buf_idx = 1'b0; st_set(0, 0, 0);
      bus.m_waitrequest = 1'b0;
      m_latest = 0; m_fresh = 0; m_have = 0; m_rd = 0; m_err = 0;
      m_frames = '0; m_skips = '0;

      tbl[0] = '{1'b1, 30'h100,      0, 32'h0010_0000, 1};
      tbl[1] = '{1'b0, 30'h40,       3, 32'h0000_0000, 4};
      tbl[2] = '{1'b1, 30'h100,      3, 32'h0010_0000, 4};
      tbl[3] = '{1'b0, 30'h3FFFFFFF, 1, 32'h0000_0000, 2};

      repeat (3) tick();
      check("rst_m_write", 64'(bus.m_write), 64'(0));
      check("rst_m_address", 64'(bus.m_address), 64'(0));
      check("rst_m_writedata", 64'(bus.m_writedata), 64'(0));
      check("rst_byteenable", 64'(bus.m_byteenable), 64'(4'hF));
      check("rst_rd_active", 64'(rd_active), 64'(0));
      check("rst_rd_buf_idx", 64'(rd_buf_idx), 64'(0));
      check_counters();
      rst = 1'b0;
      tick();

      // Table: basic frame, stalls in WR_LEN, ping-pong addresses
      foreach (tbl[i]) begin
         wdone(tbl[i].idx);
         len_stall_left = tbl[i].stall;
         n0 = wq.size();
         frame_req(tbl[i].words, 1'b1, 1'b0, 0);
         check("tbl_rd_buf", 64'(rd_buf_idx), 64'(tbl[i].idx));
         check("tbl_len_cycles", 64'(len_cycles), 64'(tbl[i].exp_len));
         if (wq.size() >= n0 + 4) begin
            check("tbl_addr", 64'(wq[n0][31:0]), 64'(tbl[i].exp_addr));
            if (tbl[i].stall == 0) begin
               check("tbl_first_lat", 64'(wc[n0] - fs_cyc), 64'(1));
               check("tbl_prog_back2back", 64'(wc[n0+2] - wc[n0]), 64'(2));
               check("tbl_dis_lat", 64'(wc[n0+3] - eop_cyc), 64'(1));
            end
         end
      end

      // No new buffer since the last frame
      frame_req(30'h10, 1'b1, 1'b0, 0);
`ifdef DMA_SEQ_REPEAT_EN
      check("repeat_reread", 64'(frame_cnt), 64'(5));
`else
      check("nofresh_skip", 64'(skip_cnt), 64'(1));
`endif

      // wr_buf_done coincident with frame_start, then the following request
      frame_req(30'h10, 1'b1, 1'b1, 0);
      frame_req(30'h20, 1'b1, 1'b0, 0);

      // zero word count and disabled sequencer are skipped
      wdone(1'b1);
      frame_req(30'h0, 1'b1, 1'b0, 0);
      frame_req(30'h5, 1'b0, 1'b0, 0);

      // EOP beat while idle
      n0 = wq.size();
      st_set(1, 1, 1); tick(); st_set(0, 0, 0); tick();
      check("idle_eop_no_write", 64'(wq.size()), 64'(n0));
      check("idle_eop_frames", 64'(frame_cnt), 64'(m_frames));

      // overlap in RUN: other buffer (no error), then same buffer (error)
      frame_req(30'h8, 1'b1, 1'b0, 2);
      check("no_conflict", 64'(err_conflict), 64'(0));
      frame_req(30'h9, 1'b1, 1'b0, 1);
      check("conflict_set", 64'(err_conflict), 64'(1));

      // reset mid-frame
      wdone(1'b1);
      cfg_words = 30'h9; cfg_enable = 1'b1; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (5) tick();
      check("pre_rst_active", 64'(rd_active), 64'(1));
      rst = 1'b1;
      tick();
      prev_stall = 1'b0;
      check("mid_rst_m_write", 64'(bus.m_write), 64'(0));
      check("mid_rst_m_address", 64'(bus.m_address), 64'(0));
      check("mid_rst_m_writedata", 64'(bus.m_writedata), 64'(0));
      check("mid_rst_rd_active", 64'(rd_active), 64'(0));
      check("mid_rst_rd_buf_idx", 64'(rd_buf_idx), 64'(0));
      m_latest = 0; m_fresh = 0; m_have = 0; m_rd = 0; m_err = 0;
      m_frames = '0; m_skips = '0;
      check_counters();
      rst = 1'b0;
      wq.delete(); wc.delete();
      tick();
      frame_req(30'h5, 1'b1, 1'b0, 0);

      // randomized traffic with random bus stalls
      rand_stall = 1'b1;
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: wdone(1'($urandom_range(0, 1)));
            1, 2: frame_req(($urandom_range(0, 7) == 0) ? 30'd0 : 30'($urandom_range(1, 1000)),
                            $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                            int'($urandom_range(0, 3)));
            3: begin
               wdone(1'($urandom_range(0, 1)));
               wdone(1'($urandom_range(0, 1)));
            end
            default: begin
               st_set(1, 1, 1); tick(); st_set(0, 0, 0); tick();
               check("rand_idle_eop", 64'(rd_active), 64'(0));
               check_counters();
            end
         endcase
      end
      rand_stall = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
